mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage controller on the consumer side of the EX/MEM pipeline register. Takes the latched EX/MEM fields, runs a req/ack handshake with a variable-latency data memory for loads and stores, and stalls the upstream pipeline while an access is outstanding. Resolves the branch decision and owns the MEM/WB pipeline register, inserting a bubble on every stall cycle.

## Interface
- MAX_WAIT, 15: cycles in ACCESS without ack before abort (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- ex_pc_sum  in  64  branch target from EX/MEM
- ex_alu_result  in  64  ALU result / memory address from EX/MEM
- ex_store_data  in  64  store data (rs2) from EX/MEM
- ex_branch, ex_zero, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  in  1 each  EX/MEM control bits
- ex_rd  in  5  destination register from EX/MEM
- dmem_req  out  1  memory request, held until ack or abort
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  64  access address
- dmem_wdata  out  64  store data
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  64  load data, valid when dmem_ack=1
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- pc_src  out  1  take branch (combinational)
- branch_target  out  64  = ex_pc_sum
- wb_alu_result, wb_read_data  out  64 each  MEM/WB data
- wb_rd  out  5  MEM/WB destination
- wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB control
- timeout_err  out  1  sticky: an access was aborted

## Operation
- mem_op = ex_mem_read | ex_mem_write; both high treated as store.
- States: IDLE, ACCESS.
- IDLE, mem_op=0: stall=0; at edge MEM/WB loads ex_alu_result, ex_rd, ex_reg_write, ex_mem_to_reg; wb_read_data=0.
- IDLE, mem_op=1: stall=1; at edge → ACCESS, dmem_req←1, dmem_we←ex_mem_write, dmem_addr←ex_alu_result, dmem_wdata←ex_store_data, wait counter←0; MEM/WB loads bubble.
- ACCESS, dmem_ack=0, counter<MAX_WAIT−1: stall=1, counter+1, bubble into MEM/WB; dmem_* held stable.
- ACCESS, dmem_ack=1: stall=0; at edge → IDLE, dmem_req←0; MEM/WB loads EX/MEM fields, wb_read_data←dmem_rdata for loads, 0 for stores.
- ACCESS, dmem_ack=0, counter=MAX_WAIT−1: abort; stall=0; at edge → IDLE, dmem_req←0, timeout_err←1; MEM/WB loads EX/MEM fields with wb_read_data=0.
- Bubble: wb_reg_write=0, wb_mem_to_reg=0, wb_rd=0, data fields 0.
- dmem_ack in IDLE ignored.
- pc_src = ex_branch & ex_zero & ~stall; branch_target = ex_pc_sum.
- Counter width clog2(MAX_WAIT+1); saturates, never wraps.

## Timing
- Reset (async, immediate): state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, all wb_* =0, counter=0, timeout_err=0. Reset mid-ACCESS drops req in same cycle, without waiting for ack; late ack after reset release is ignored.
- Non-memory instruction: 1 cycle in MEM, no stall.
- Memory op with ack in first ACCESS cycle: 2 cycles, 1 stall cycle; ack after N ACCESS cycles gives N stall cycles.
- Abort: exactly MAX_WAIT ACCESS cycles, then release.
- stall and pc_src are combinational from state, EX/MEM inputs and dmem_ack; all other outputs are registered.
- Back-to-back memory ops: IDLE for one cycle between accesses, so dmem_req deasserts for ≥1 cycle.
- timeout_err cleared only by reset.

## Test plan
- ALU op, ex_alu_result=0x1234, ex_rd=5, ex_reg_write=1 -> next edge wb_alu_result=0x1234, wb_rd=5, wb_reg_write=1; stall never high.
- Load addr 0x40, ack on 3rd ACCESS cycle with rdata=0xDEADBEEF -> dmem_req high 3 cycles, we=0, addr=0x40; stall high 3 cycles; wb_read_data=0xDEADBEEF, wb_mem_to_reg=1; bubbles in between.
- Store addr 0x80, data 0x55 with immediate ack -> one cycle with dmem_req=1, we=1, wdata=0x55; stall 1 cycle; wb_reg_write=0 if ex_reg_write=0.
- Load with no ack, MAX_WAIT=15 -> req high exactly 15 cycles, then req=0, timeout_err=1, wb_read_data=0, pipeline resumes.
- Branch with ex_zero=1, ex_pc_sum=0x100 -> pc_src=1, branch_target=0x100 same cycle; with ex_zero=0 -> pc_src=0.
- Reset asserted on 2nd ACCESS cycle -> dmem_req, wb_*, timeout_err go 0 immediately; ack arriving after reset release is ignored, state IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage controller: runs the req/ack data-memory handshake, stalls upstream while an
// access is outstanding, resolves branches and owns the MEM/WB pipeline register.
module mem_access_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] ex_pc_sum,
    input  logic [63:0] ex_alu_result,
    input  logic [63:0] ex_store_data,
    input  logic        ex_branch,
    input  logic        ex_zero,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        stall,
    output logic        pc_src,
    output logic [63:0] branch_target,
    output logic [63:0] wb_alu_result,
    output logic [63:0] wb_read_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic        timeout_err
);
    // state  | meaning
    // IDLE   | no access outstanding; non-memory ops pass straight to MEM/WB
    // ACCESS | request on the bus, waiting for ack or the MAX_WAIT abort
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            w_mem_op;
    logic            w_cnt_last;
    logic            w_start;
    logic            w_finish;
    logic            w_abort;
    logic            w_wb_load;

    assign w_mem_op      = ex_mem_read | ex_mem_write;
    assign w_cnt_last    = (r_cnt == CW'(MAX_WAIT - 1));
    assign pc_src        = ex_branch & ex_zero & ~stall;
    assign branch_target = ex_pc_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_mem_op)               w_next = S_ACCESS;
            S_ACCESS: if (dmem_ack || w_cnt_last) w_next = S_IDLE;
            default:                              w_next = S_IDLE;
        endcase
    end

    // ack wins over abort when both land on the last wait cycle
    always_comb begin
        stall     = 1'b0;
        w_start   = 1'b0;
        w_finish  = 1'b0;
        w_abort   = 1'b0;
        w_wb_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    stall   = 1'b1;
                    w_start = 1'b1;
                end else begin
                    w_wb_load = 1'b1;
                end
            end
            S_ACCESS: begin
                if (dmem_ack) begin
                    w_finish  = 1'b1;
                    w_wb_load = 1'b1;
                end else if (w_cnt_last) begin
                    w_finish  = 1'b1;
                    w_abort   = 1'b1;
                    w_wb_load = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            r_cnt         <= '0;
            timeout_err   <= 1'b0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
        end else begin
            if (w_start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= ex_mem_write;
                dmem_addr  <= ex_alu_result;
                dmem_wdata <= ex_store_data;
                r_cnt      <= '0;
            end else if (w_finish) begin
                dmem_req <= 1'b0;
            end else if (r_state == S_ACCESS && !w_cnt_last) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_abort) timeout_err <= 1'b1;

            if (w_wb_load) begin
                wb_alu_result <= ex_alu_result;
                wb_rd         <= ex_rd;
                wb_reg_write  <= ex_reg_write;
                wb_mem_to_reg <= ex_mem_to_reg;
                wb_read_data  <= (r_state == S_ACCESS && dmem_ack && !dmem_we) ? dmem_rdata : '0;
            end else begin
                wb_alu_result <= '0;
                wb_rd         <= '0;
                wb_reg_write  <= 1'b0;
                wb_mem_to_reg <= 1'b0;
                wb_read_data  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single-cycle ALU/branch vectors plus
// hand sequences for load, store, timeout abort, back-to-back ops and mid-access reset.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ex_pc_sum, ex_alu_result, ex_store_data;
    logic        ex_branch, ex_zero, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, pc_src;
    logic [63:0] branch_target, wb_alu_result, wb_read_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, wb_mem_to_reg, timeout_err;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .ex_pc_sum(ex_pc_sum), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        rw, m2r, br, zero;
        logic [63:0] pc;
        logic        exp_pc_src;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_ex(input logic [63:0] alu, input logic [4:0] rd, input logic rw,
                          input logic m2r, input logic rd_op, input logic wr_op,
                          input logic [63:0] sdata);
        ex_alu_result = alu; ex_rd = rd; ex_reg_write = rw; ex_mem_to_reg = m2r;
        ex_mem_read = rd_op; ex_mem_write = wr_op; ex_store_data = sdata;
    endtask

    task automatic nop();
        set_ex(64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        ex_branch = 1'b0; ex_zero = 1'b0; ex_pc_sum = 64'h0;
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_wb_rw"},   64'(wb_reg_write),  64'h0);
        chk({name, "_wb_rd"},   64'(wb_rd),         64'h0);
        chk({name, "_wb_alu"},  wb_alu_result,      64'h0);
        chk({name, "_wb_data"}, wb_read_data,       64'h0);
    endtask

    vec_t vecs[5];
    int   n_req, n_stall;

    initial begin
        vecs[0] = '{alu:64'h1234, rd:5'd5, rw:1'b1, m2r:1'b0, br:1'b0, zero:1'b0, pc:64'h0, exp_pc_src:1'b0};
        vecs[1] = '{alu:64'h0, rd:5'd0, rw:1'b0, m2r:1'b0, br:1'b1, zero:1'b1, pc:64'h100, exp_pc_src:1'b1};
        vecs[2] = '{alu:64'h7, rd:5'd0, rw:1'b0, m2r:1'b0, br:1'b1, zero:1'b0, pc:64'h200, exp_pc_src:1'b0};
        vecs[3] = '{alu:64'hFFFF_FFFF_FFFF_FFFF, rd:5'd31, rw:1'b1, m2r:1'b1, br:1'b0, zero:1'b1, pc:64'h300, exp_pc_src:1'b0};
        vecs[4] = '{alu:64'hA5A5, rd:5'd12, rw:1'b1, m2r:1'b0, br:1'b1, zero:1'b1, pc:64'hFFFF_0000, exp_pc_src:1'b1};

        reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        nop();
        #1;
        chk("rst_req", 64'(dmem_req), 64'h0);
        chk("rst_we", 64'(dmem_we), 64'h0);
        chk("rst_addr", dmem_addr, 64'h0);
        chk("rst_terr", 64'(timeout_err), 64'h0);
        chk_bubble("rst");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Single-cycle ALU / branch vectors
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_ex(vecs[i].alu, vecs[i].rd, vecs[i].rw, vecs[i].m2r, 1'b0, 1'b0, 64'h0);
            ex_branch = vecs[i].br; ex_zero = vecs[i].zero; ex_pc_sum = vecs[i].pc;
            #1;
            chk($sformatf("v%0d_stall", i), 64'(stall), 64'h0);
            chk($sformatf("v%0d_pc_src", i), 64'(pc_src), 64'(vecs[i].exp_pc_src));
            chk($sformatf("v%0d_target", i), branch_target, vecs[i].pc);
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb_alu", i), wb_alu_result, vecs[i].alu);
            chk($sformatf("v%0d_wb_rd", i), 64'(wb_rd), 64'(vecs[i].rd));
            chk($sformatf("v%0d_wb_rw", i), 64'(wb_reg_write), 64'(vecs[i].rw));
            chk($sformatf("v%0d_wb_m2r", i), 64'(wb_mem_to_reg), 64'(vecs[i].m2r));
            chk($sformatf("v%0d_wb_data", i), wb_read_data, 64'h0);
            chk($sformatf("v%0d_req", i), 64'(dmem_req), 64'h0);
        end

        // Load at 0x40, ack on 3rd ACCESS cycle; branch bits set to see pc_src masking
        @(negedge clk);
        nop();
        set_ex(64'h40, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        ex_branch = 1'b1; ex_zero = 1'b1;
        #1;
        chk("ld_idle_stall", 64'(stall), 64'h1);
        chk("ld_idle_pc_src", 64'(pc_src), 64'h0);
        @(posedge clk); #1;
        chk_bubble("ld_b0");
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 3) begin dmem_ack = 1'b1; dmem_rdata = 64'hDEADBEEF; end
            #1;
            chk($sformatf("ld_a%0d_req", k), 64'(dmem_req), 64'h1);
            chk($sformatf("ld_a%0d_we", k), 64'(dmem_we), 64'h0);
            chk($sformatf("ld_a%0d_addr", k), dmem_addr, 64'h40);
            chk($sformatf("ld_a%0d_stall", k), 64'(stall), (k < 3) ? 64'h1 : 64'h0);
            chk($sformatf("ld_a%0d_pc_src", k), 64'(pc_src), (k < 3) ? 64'h0 : 64'h1);
            @(posedge clk); #1;
            if (k < 3) chk_bubble($sformatf("ld_a%0d", k));
        end
        chk("ld_req_drop", 64'(dmem_req), 64'h0);
        chk("ld_wb_data", wb_read_data, 64'hDEADBEEF);
        chk("ld_wb_m2r", 64'(wb_mem_to_reg), 64'h1);
        chk("ld_wb_rd", 64'(wb_rd), 64'h7);
        chk("ld_wb_alu", wb_alu_result, 64'h40);
        chk("ld_terr", 64'(timeout_err), 64'h0);

        // Store 0x80 / 0x55 with immediate ack, then back-to-back store to 0x88
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 64'h1111;
        nop();
        set_ex(64'h80, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 64'h55);
        #1;
        chk("st_idle_stall", 64'(stall), 64'h1);
        @(posedge clk); #1;
        chk("st_req", 64'(dmem_req), 64'h1);
        chk("st_we", 64'(dmem_we), 64'h1);
        chk("st_addr", dmem_addr, 64'h80);
        chk("st_wdata", dmem_wdata, 64'h55);
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        chk("st_ack_stall", 64'(stall), 64'h0);
        @(posedge clk); #1;
        chk("st_req_drop", 64'(dmem_req), 64'h0);
        chk("st_wb_rw", 64'(wb_reg_write), 64'h0);
        chk("st_wb_data", wb_read_data, 64'h0);
        chk("st_wb_alu", wb_alu_result, 64'h80);
        @(negedge clk);
        dmem_ack = 1'b0;
        set_ex(64'h88, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 64'h66);
        #1;
        chk("b2b_gap_req", 64'(dmem_req), 64'h0);
        chk("b2b_gap_stall", 64'(stall), 64'h1);
        @(posedge clk); #1;
        chk("b2b_req", 64'(dmem_req), 64'h1);
        chk("b2b_we", 64'(dmem_we), 64'h1);
        chk("b2b_addr", dmem_addr, 64'h88);
        @(negedge clk); dmem_ack = 1'b1;
        @(posedge clk); #1;
        chk("b2b_done", 64'(dmem_req), 64'h0);

        // Load with no ack: abort after exactly 15 ACCESS cycles
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 64'hBEEF;
        nop();
        set_ex(64'h200, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        n_req = 0; n_stall = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (stall) n_stall++;
            if (dmem_req) n_req++;
            @(posedge clk); #1;
            if (!dmem_req && n_req > 0) break;
            @(negedge clk);
        end
        chk("to_req_cycles", 64'(n_req), 64'd15);
        chk("to_stall_cycles", 64'(n_stall), 64'd15);
        chk("to_terr", 64'(timeout_err), 64'h1);
        chk("to_wb_data", wb_read_data, 64'h0);
        chk("to_wb_rd", 64'(wb_rd), 64'd9);
        chk("to_wb_rw", 64'(wb_reg_write), 64'h1);
        @(negedge clk);
        nop();
        set_ex(64'h77, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        #1;
        chk("to_resume_stall", 64'(stall), 64'h0);
        @(posedge clk); #1;
        chk("to_resume_wb", wb_alu_result, 64'h77);
        chk("to_sticky", 64'(timeout_err), 64'h1);

        // Reset on 2nd ACCESS cycle, then a late ack must be ignored
        @(negedge clk);
        set_ex(64'h300, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rm_req_before", 64'(dmem_req), 64'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rm_req", 64'(dmem_req), 64'h0);
        chk("rm_terr", 64'(timeout_err), 64'h0);
        chk_bubble("rm");
        nop();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 64'hBAD;
        #1;
        chk("late_ack_stall", 64'(stall), 64'h0);
        @(posedge clk); #1;
        chk("late_ack_req", 64'(dmem_req), 64'h0);
        chk("late_ack_data", wb_read_data, 64'h0);
        chk("late_ack_terr", 64'(timeout_err), 64'h0);
        @(negedge clk);
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("late_ack_idle", 64'(dmem_req), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
